x2c_ctrl_sfifo: RTL and testbench
=================================

# x2c_ctrl_sfifo

Parametrised single-clock control FIFO for the x2c control path, the next generation of the x2c control FIFOs. Adds selectable normal/show-ahead read mode, programmable almost-full/almost-empty flags, synchronous clear and sticky overflow/underflow error flags. Used where producer and consumer of control words share one clock domain.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 1024, number of storage words; must equal 2**PTR
- PTR, 10, pointer width
- SHOWAHEAD, 0, 0 = normal read (q one cycle after rdreq), 1 = show-ahead (q presents head word while !empty)
- AFULL_LVL, DEPTH-4, almost_full asserts when usedw >= AFULL_LVL
- AEMPTY_LVL, 4, almost_empty asserts when usedw <= AEMPTY_LVL
- clk  in  1  the single clock; all logic on rising edge
- reset_  in  1  asynchronous, active-low reset
- sclr  in  1  synchronous clear of pointers, count, flags, q
- wrreq  in  1  write request
- data  in  WIDTH  write data
- full  out  1  usedw == DEPTH
- almost_full  out  1  usedw >= AFULL_LVL
- rdreq  in  1  read request (pop)
- q  out  WIDTH  read data
- empty  out  1  no readable word
- almost_empty  out  1  usedw <= AEMPTY_LVL
- usedw  out  PTR+1  words currently stored (0..DEPTH)
- ovf  out  1  sticky: write attempted while full
- udf  out  1  sticky: read attempted while empty
- err_clr  in  1  clears ovf/udf

## Operation
- Write accepted when wrreq && !full; word stored at wr_ptr, wr_ptr increments mod DEPTH.
- wrreq && full: word dropped, pointers unchanged, ovf set — regardless of rdreq in the same cycle.
- Read accepted when rdreq && !empty; rd_ptr increments mod DEPTH.
- rdreq && empty: ignored, q holds, udf set.
- Simultaneous accepted read and write: usedw unchanged; legal at any non-empty, non-full level.
- usedw: +1 on write only, -1 on read only; never exceeds DEPTH nor goes below 0.
- Pointers are PTR bits and wrap from DEPTH-1 to 0; usedw distinguishes full from empty.
- Show-ahead: internal prefetch register loads the RAM head whenever it is empty or being popped and RAM holds data; empty reflects prefetch-register-valid; usedw counts RAM words plus prefetch word.
- ovf/udf: set on the offending cycle, held until err_clr or sclr or reset; err_clr and a new error in the same cycle -> flag ends set.
- sclr: pointers, usedw, prefetch valid, q, ovf, udf to 0; wrreq/rdreq in that cycle ignored (no ovf/udf set). sclr overrides err_clr.
- Reset (reset_=0, async): same values as sclr, applied immediately; aborts any in-flight prefetch.

## Timing
- Reset values: q=0, usedw=0, empty=1, almost_empty=1, full=0, almost_full=0 (AFULL_LVL>0), ovf=0, udf=0.
- All outputs registered; flags and usedw reflect state after the edge that accepted the operation.
- Normal mode: write at edge T -> usedw=1, empty=0 after T; rdreq accepted at T+1 -> q valid after edge T+1 (latency 1); q holds between reads.
- Show-ahead: write into empty FIFO at edge T -> usedw=1 after T, q=data and empty=0 after T+1; rdreq at edge with !empty pops current q, next word appears on q after the same edge if RAM non-empty, else empty=1.
- full deasserts the edge after an accepted read; may reassert the same edge by a simultaneous write only if level unchanged at DEPTH (impossible: write blocked when full).
- RAM read port: one-cycle registered.

## Structure
- Shared package x2c_fifo_pkg: default WIDTH/DEPTH/PTR constants and a clog2 function; SHOWAHEAD mode encodings.
- One sub-module x2c_sdpram: WIDTH x DEPTH simple dual-port RAM, one write port, one registered read port, same clk; no reset on array.
- Top holds pointers, counter, flag registers and the show-ahead prefetch stage.

## Test plan
- Reset then write 0x11,0x22,0x33 (normal mode) and read 3 -> q=0x11,0x22,0x33 each one cycle after rdreq; usedw 3->0; empty=1 after last read.
- Fill 1024 words -> full=1 and usedw=1024 after 1024th write; almost_full=1 at usedw=1020; extra wrreq -> ovf=1, contents unchanged on readback.
- Read on empty FIFO -> udf=1, q unchanged; err_clr pulse -> udf=0 next edge.
- Write/read 3000 words at random overlap including simultaneous rd/wr at usedw=1024 and 0 -> order preserved across pointer wrap, usedw exact each cycle.
- SHOWAHEAD=1: single write 0xA5 at edge T -> q=0xA5, empty=0 after T+1; rdreq -> empty=1 next edge.
- Assert reset_ mid-burst (usedw=500) and separately sclr -> all outputs to reset values; subsequent write/read of 0x5A returns 0x5A.

Source files
------------

// File: rtl/x2c_fifo_pkg.sv
// rtl/x2c_fifo_pkg.sv - shared constants, read-mode encodings and clog2 helper for x2c FIFOs
package x2c_fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_PTR   = 10;

  // Read-mode encodings for the SHOWAHEAD parameter
  localparam int SA_NORMAL    = 0;
  localparam int SA_SHOWAHEAD = 1;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/x2c_sdpram.sv
// rtl/x2c_sdpram.sv - WIDTH x DEPTH simple dual-port RAM with one registered read port
module x2c_sdpram
  import x2c_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array write port; the array itself is never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; the output register is clearable and holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/x2c_ctrl_sfifo.sv
// rtl/x2c_ctrl_sfifo.sv - single-clock control FIFO with normal/show-ahead read and status flags
module x2c_ctrl_sfifo
  import x2c_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PTR        = DEF_PTR,
  parameter int SHOWAHEAD  = SA_NORMAL,
  parameter int AFULL_LVL  = DEPTH - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             almost_full,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             almost_empty,
  output logic [PTR:0]     usedw,
  output logic             ovf,
  output logic             udf,
  input  logic             err_clr
);

  localparam logic [PTR:0] DEPTH_W  = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] AFULL_W  = (PTR+1)'(AFULL_LVL);
  localparam logic [PTR:0] AEMPTY_W = (PTR+1)'(AEMPTY_LVL);
  localparam logic         AF_RST   = (AFULL_LVL <= 0);
  localparam logic         AE_RST   = (AEMPTY_LVL >= 0);
  localparam bit           SA_MODE  = (SHOWAHEAD == SA_SHOWAHEAD);

  logic [PTR-1:0] wr_ptr;
  logic [PTR-1:0] rd_ptr;
  logic           pf_valid;

  logic           wr_ok;
  logic           rd_ok;
  logic           ram_rd;
  logic           pf_valid_nxt;
  logic [PTR:0]   usedw_nxt;
  logic           empty_nxt;

  // Accepted operations; sclr swallows both requests in its cycle
  assign wr_ok = wrreq && !full  && !sclr;
  assign rd_ok = rdreq && !empty && !sclr;

  // Next-state for the occupancy count, RAM read issue and prefetch stage
  always_comb begin
    ram_rd       = 1'b0;
    pf_valid_nxt = pf_valid;
    usedw_nxt    = usedw;
    empty_nxt    = empty;

    if (SA_MODE) begin
      // In show-ahead the RAM output register doubles as the prefetch word:
      // refill it whenever it is vacant or being popped and the RAM still
      // holds words behind it.
      if ((usedw > {{PTR{1'b0}}, pf_valid}) && (!pf_valid || rd_ok)) begin
        ram_rd       = 1'b1;
        pf_valid_nxt = 1'b1;
      end else if (rd_ok) begin
        pf_valid_nxt = 1'b0;
      end
    end else begin
      ram_rd = rd_ok;
    end

    case ({wr_ok, rd_ok})
      2'b10:   usedw_nxt = usedw + 1'b1;
      2'b01:   usedw_nxt = usedw - 1'b1;
      default: usedw_nxt = usedw;
    endcase

    if (sclr) begin
      ram_rd       = 1'b0;
      pf_valid_nxt = 1'b0;
      usedw_nxt    = '0;
    end

    empty_nxt = SA_MODE ? !pf_valid_nxt : (usedw_nxt == '0);
  end

  // Write and read pointers, wrapping naturally at DEPTH
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered occupancy, prefetch valid and level flags
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      usedw        <= '0;
      pf_valid     <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= AF_RST;
      almost_empty <= AE_RST;
    end else begin
      usedw        <= usedw_nxt;
      pf_valid     <= pf_valid_nxt;
      empty        <= empty_nxt;
      full         <= (usedw_nxt == DEPTH_W);
      almost_full  <= (usedw_nxt >= AFULL_W);
      almost_empty <= (usedw_nxt <= AEMPTY_W);
    end
  end

  // Sticky error flags; a new error wins over err_clr, sclr wins over both
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (sclr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (ovf && !err_clr) || (wrreq && full);
      udf <= (udf && !err_clr) || (rdreq && empty);
    end
  end

  x2c_sdpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_),
    .clr     (sclr),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr),
    .rd_data (q)
  );

endmodule

// File: tb/tb_x2c_ctrl_sfifo.sv
// tb/tb_x2c_ctrl_sfifo.sv - randomized self-checking bench for x2c_ctrl_sfifo in both read modes
module tb_x2c_ctrl_sfifo;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset_;
  logic        sclr;
  logic        wrreq;
  logic [31:0] data;
  logic        rdreq;
  logic        err_clr;

  logic        n_full, n_afull, n_empty, n_aempty, n_ovf, n_udf;
  logic [31:0] n_q;
  logic [10:0] n_usedw;
  logic        s_full, s_afull, s_empty, s_aempty, s_ovf, s_udf;
  logic [31:0] s_q;
  logic [10:0] s_usedw;

  int n_checks;
  int n_errors;

  // Reference state: normal mode
  logic [31:0] nfifo[$];
  logic [31:0] m_nq;
  logic        m_novf, m_nudf;
  // Reference state: show-ahead mode
  logic [31:0] sfifo[$];
  logic [31:0] m_sq;
  logic        m_sv, m_sovf, m_sudf;

  x2c_ctrl_sfifo u_dut_n (
    .clk (clk), .reset_ (reset_), .sclr (sclr), .wrreq (wrreq), .data (data),
    .full (n_full), .almost_full (n_afull), .rdreq (rdreq), .q (n_q),
    .empty (n_empty), .almost_empty (n_aempty), .usedw (n_usedw),
    .ovf (n_ovf), .udf (n_udf), .err_clr (err_clr)
  );

  x2c_ctrl_sfifo #(.SHOWAHEAD(1)) u_dut_s (
    .clk (clk), .reset_ (reset_), .sclr (sclr), .wrreq (wrreq), .data (data),
    .full (s_full), .almost_full (s_afull), .rdreq (rdreq), .q (s_q),
    .empty (s_empty), .almost_empty (s_aempty), .usedw (s_usedw),
    .ovf (s_ovf), .udf (s_udf), .err_clr (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    nfifo.delete();
    sfifo.delete();
    m_nq = '0; m_novf = 1'b0; m_nudf = 1'b0;
    m_sq = '0; m_sv = 1'b0; m_sovf = 1'b0; m_sudf = 1'b0;
  endtask

  // Apply the FIFO rules to the inputs seen at the edge just taken
  task automatic model_update();
    logic [31:0] dummy;
    logic        nfull, nemp, sfull;
    int          behind;
    if (sclr) begin
      model_reset();
      return;
    end
    nfull = (nfifo.size() == DEPTH);
    nemp  = (nfifo.size() == 0);
    m_novf = (m_novf && !err_clr) || (wrreq && nfull);
    m_nudf = (m_nudf && !err_clr) || (rdreq && nemp);
    if (rdreq && !nemp) m_nq = nfifo.pop_front();
    if (wrreq && !nfull) nfifo.push_back(data);

    sfull  = (sfifo.size() == DEPTH);
    behind = sfifo.size() - (m_sv ? 1 : 0);
    m_sovf = (m_sovf && !err_clr) || (wrreq && sfull);
    m_sudf = (m_sudf && !err_clr) || (rdreq && !m_sv);
    if (rdreq && m_sv) begin
      dummy = sfifo.pop_front();
      if (behind > 0) m_sq = sfifo[0];
      else            m_sv = 1'b0;
    end else if (!m_sv && behind > 0) begin
      m_sv = 1'b1;
      m_sq = sfifo[0];
    end
    if (wrreq && !sfull) sfifo.push_back(data);
  endtask

  task automatic compare_all();
    int ns, ss;
    ns = nfifo.size();
    ss = sfifo.size();
    chk("n_usedw",  32'(n_usedw),  32'(ns));
    chk("n_empty",  32'(n_empty),  32'(ns == 0));
    chk("n_full",   32'(n_full),   32'(ns == DEPTH));
    chk("n_afull",  32'(n_afull),  32'(ns >= DEPTH - 4));
    chk("n_aempty", 32'(n_aempty), 32'(ns <= 4));
    chk("n_q",      n_q,           m_nq);
    chk("n_ovf",    32'(n_ovf),    32'(m_novf));
    chk("n_udf",    32'(n_udf),    32'(m_nudf));
    chk("s_usedw",  32'(s_usedw),  32'(ss));
    chk("s_empty",  32'(s_empty),  32'(!m_sv));
    chk("s_full",   32'(s_full),   32'(ss == DEPTH));
    chk("s_afull",  32'(s_afull),  32'(ss >= DEPTH - 4));
    chk("s_aempty", 32'(s_aempty), 32'(ss <= 4));
    chk("s_q",      s_q,           m_sq);
    chk("s_ovf",    32'(s_ovf),    32'(m_sovf));
    chk("s_udf",    32'(s_udf),    32'(m_sudf));
  endtask

  task automatic check_rst_vals(input string tag);
    chk({tag, "_nq"},      n_q,             32'h0);
    chk({tag, "_nusedw"},  32'(n_usedw),    32'd0);
    chk({tag, "_nempty"},  32'(n_empty),    32'd1);
    chk({tag, "_naempty"}, 32'(n_aempty),   32'd1);
    chk({tag, "_nfull"},   32'(n_full),     32'd0);
    chk({tag, "_nafull"},  32'(n_afull),    32'd0);
    chk({tag, "_novf"},    32'(n_ovf),      32'd0);
    chk({tag, "_nudf"},    32'(n_udf),      32'd0);
    chk({tag, "_sq"},      s_q,             32'h0);
    chk({tag, "_susedw"},  32'(s_usedw),    32'd0);
    chk({tag, "_sempty"},  32'(s_empty),    32'd1);
    chk({tag, "_sovf"},    32'(s_ovf),      32'd0);
  endtask

  task automatic step(input logic w, input logic r, input logic [31:0] d,
                      input logic c, input logic e);
    @(negedge clk);
    wrreq = w; rdreq = r; data = d; sclr = c; err_clr = e;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    int pw, pr, ph;
    n_checks = 0;
    n_errors = 0;
    reset_ = 1'b0; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_rst_vals("rst");
    compare_all();
    @(negedge clk);
    reset_ = 1'b1;

    // Normal-mode basic order and latency
    step(1, 0, 32'h11, 0, 0);
    step(1, 0, 32'h22, 0, 0);
    step(1, 0, 32'h33, 0, 0);
    chk("basic_usedw3", 32'(n_usedw), 32'd3);
    step(0, 1, 32'h0, 0, 0);
    chk("basic_q11", n_q, 32'h11);
    step(0, 1, 32'h0, 0, 0);
    chk("basic_q22", n_q, 32'h22);
    step(0, 1, 32'h0, 0, 0);
    chk("basic_q33", n_q, 32'h33);
    chk("basic_empty", 32'(n_empty), 32'd1);

    // Fill to full, overflow, then drain and verify contents
    for (int i = 0; i < DEPTH; i++) step(1, 0, $urandom, 0, 0);
    chk("fill_full", 32'(n_full), 32'd1);
    chk("fill_usedw", 32'(n_usedw), 32'd1024);
    step(1, 1'b0, 32'hDEADBEEF, 0, 0);
    chk("fill_ovf", 32'(n_ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h0, 0, 0);

    // Underflow and err_clr
    step(0, 1, 32'h0, 0, 0);
    chk("udf_set", 32'(n_udf), 32'd1);
    step(0, 0, 32'h0, 0, 1);
    chk("udf_clr", 32'(n_udf), 32'd0);

    // Randomized traffic with phases that reach both full and empty
    for (int i = 0; i < 6000; i++) begin
      ph = (i / 1500) % 4;
      pw = (ph == 0) ? 90 : (ph == 2) ? 20 : 60;
      pr = (ph == 0) ? 20 : (ph == 2) ? 90 : 60;
      step(1'($urandom_range(99) < pw), 1'($urandom_range(99) < pr), $urandom,
           0, 1'($urandom_range(63) == 0));
    end

    // Synchronous clear with requests in the same cycle
    for (int i = 0; i < 300; i++) step(1, 0, $urandom, 0, 0);
    step(1, 1, 32'h12345678, 1, 1);
    check_rst_vals("sclr");
    step(1, 0, 32'h5A, 0, 0);
    step(0, 0, 32'h0, 0, 0);
    step(0, 1, 32'h0, 0, 0);
    chk("sclr_rd5a", n_q, 32'h5A);

    // Show-ahead timing for a single word
    step(1, 0, 32'hA5, 0, 0);
    chk("sa_usedw1", 32'(s_usedw), 32'd1);
    chk("sa_empty_T", 32'(s_empty), 32'd1);
    step(0, 0, 32'h0, 0, 0);
    chk("sa_q_a5", s_q, 32'hA5);
    chk("sa_empty_T1", 32'(s_empty), 32'd0);
    step(0, 1, 32'h0, 0, 0);
    chk("sa_empty_pop", 32'(s_empty), 32'd1);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 500; i++) step(1, 0, $urandom, 0, 0);
    chk("burst_usedw500", 32'(n_usedw), 32'd500);
    @(negedge clk);
    wrreq = 1'b1; rdreq = 1'b0; data = $urandom; sclr = 1'b0; err_clr = 1'b0;
    #2 reset_ = 1'b0;
    #1;
    model_reset();
    check_rst_vals("arst");
    compare_all();
    @(negedge clk);
    wrreq = 1'b0;
    reset_ = 1'b1;
    step(1, 0, 32'h5A, 0, 0);
    step(0, 0, 32'h0, 0, 0);
    chk("arst_sq5a", s_q, 32'h5A);
    step(0, 1, 32'h0, 0, 0);
    chk("arst_nq5a", n_q, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
